crc_scrub_mem: RTL and testbench

Multi-word CRC-protected storage array with single-bit correction on read, automatic correction write-back, a background scrubber, and error counters. It replaces the single-register CRC memory in safety datapaths that need real depth and periodic latent-fault removal. A write-path fault-injection port is provided for FuSa campaign and verification use.

---
 rtl/crc_scrub_mem_if.sv | 43 ++++
 rtl/crc_scrub_mem.sv | 268 ++++++++++++++++++++++++++
 tb/tb_crc_scrub_mem.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_scrub_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : crc_scrub_mem_if
// Description : Request / response bundle for the CRC-protected scrubbed
//               storage array. master = requester, slave = memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface crc_scrub_mem_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CRC_W      = 8
);
  localparam int c_AW = $clog2(DEPTH);

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_wr;
  logic [c_AW-1:0]             req_addr;
  logic [DATA_WIDTH-1:0]       req_wdata;
  logic                        err_inj_en;
  logic [DATA_WIDTH+CRC_W-1:0] err_inj_mask;
  logic                        rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;
  logic                        rsp_err_det;
  logic                        rsp_err_corr;
  logic                        rsp_err_uncorr;
  logic [15:0]                 corr_cnt;
  logic [15:0]                 uncorr_cnt;
  logic [c_AW-1:0]             scrub_ptr;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, err_inj_en, err_inj_mask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err_det, rsp_err_corr,
           rsp_err_uncorr, corr_cnt, uncorr_cnt, scrub_ptr
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, err_inj_en, err_inj_mask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err_det, rsp_err_corr,
           rsp_err_uncorr, corr_cnt, uncorr_cnt, scrub_ptr
  );
endinterface
`default_nettype wire

// File: rtl/crc_scrub_mem.sv
`default_nettype none
// ============================================================================
// Module      : crc_scrub_mem
// Description : Multi-word storage array, each word kept as {crc, data}.
//               Reads are checked and single-bit errors corrected and written
//               back; a background scrubber walks the array on an interval.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_scrub_mem #(
  parameter int               DATA_WIDTH     = 16,
  parameter int               DEPTH          = 16,
  parameter int               CRC_W          = 8,
  parameter logic [CRC_W-1:0] POLY           = 8'h07,
  parameter bit               OUTPUT_FF      = 1'b1,
  parameter bit               SCRUB_EN       = 1'b1,
  parameter int               SCRUB_INTERVAL = 256
) (
  input  logic           clk,
  input  logic           rst,
  crc_scrub_mem_if.slave bus
);
  localparam int              c_AW       = $clog2(DEPTH);
  localparam int              c_WW       = DATA_WIDTH + CRC_W;
  localparam int              c_IW       = $clog2(SCRUB_INTERVAL);
  localparam logic [c_IW-1:0] c_IV_LAST  = c_IW'(SCRUB_INTERVAL - 1);
  localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(DEPTH - 1);
  localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WB    = 2'd2
  } state_t;

  // Non-reflected CRC, init 0, MSB first, no final XOR (data * x^CRC_W mod POLY)
  function automatic logic [CRC_W-1:0] crc_f(input logic [DATA_WIDTH-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_WW-1:0]       r_mem [DEPTH];
  logic [c_WW-1:0]       r_chk_word;
  logic [c_AW-1:0]       r_chk_addr;
  logic                  r_chk_scrub;
  logic [c_AW-1:0]       r_scrub_ptr;
  logic [15:0]           r_corr_cnt;
  logic [15:0]           r_uncorr_cnt;
  logic                  w_scrub_pending;
  logic                  w_scrub_issue;
  logic                  w_req_ready;
  logic                  w_acc_rd;
  logic                  w_acc_wr;
  logic                  w_req_inrange;
  logic [DATA_WIDTH-1:0] w_raw_data;
  logic [CRC_W-1:0]      w_raw_crc;
  logic [CRC_W-1:0]      w_syn;
  logic [CRC_W-1:0]      w_syn_tab [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] w_flip;
  logic                  w_data_hit;
  logic                  w_crc_hit;
  logic                  w_in_chk;
  logic                  w_det;
  logic                  w_corr;
  logic                  w_uncorr;
  logic [DATA_WIDTH-1:0] w_fixed;
  logic                  w_rsp_fire;

  assign bus.req_ready  = w_req_ready & ~rst;
  assign w_acc_rd       = bus.req_valid & bus.req_ready & ~bus.req_wr;
  assign w_acc_wr       = bus.req_valid & bus.req_ready & bus.req_wr;
  assign w_req_inrange  = ({1'b0, bus.req_addr} < c_DEPTH);

  // ------------------------------------------------------------------------
  // Check stage: syndrome and single-bit locator
  // ------------------------------------------------------------------------
  assign w_raw_data = r_chk_word[DATA_WIDTH-1:0];
  assign w_raw_crc  = r_chk_word[c_WW-1:DATA_WIDTH];
  assign w_syn      = crc_f(w_raw_data) ^ w_raw_crc;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_syn_tab
    assign w_syn_tab[gi] = crc_f(DATA_WIDTH'(1) << gi);
  end

  // Match the syndrome against the signature of every single data-bit error
  always_comb begin
    w_flip     = '0;
    w_data_hit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (w_syn == w_syn_tab[i]) begin
        w_flip[i]  = 1'b1;
        w_data_hit = 1'b1;
      end
    end
  end

  // A one-hot syndrome means only a stored CRC bit flipped; data is intact
  assign w_crc_hit  = $onehot(w_syn);
  assign w_in_chk   = (r_state == S_CHECK);
  assign w_det      = w_in_chk & (w_syn != '0);
  assign w_corr     = w_det & (w_data_hit | w_crc_hit);
  assign w_uncorr   = w_det & ~w_corr;
  assign w_fixed    = w_raw_data ^ w_flip;
  assign w_rsp_fire = w_in_chk & ~r_chk_scrub;

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, request acceptance and scrub issue; requests beat scrubs
  always_comb begin
    w_state_nxt   = r_state;
    w_req_ready   = 1'b0;
    w_scrub_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_nxt = bus.req_wr ? S_IDLE : S_CHECK;
        end else if (w_scrub_pending) begin
          w_scrub_issue = 1'b1;
          w_state_nxt   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_corr) begin
          // Array port is busy rewriting the corrected word this cycle
          w_state_nxt = S_WB;
        end else begin
          w_req_ready = 1'b1;
          w_state_nxt = (bus.req_valid & ~bus.req_wr) ? S_CHECK : S_IDLE;
        end
      end
      S_WB: begin
        // Rewrite has landed; a new request may be taken straight away
        w_req_ready = 1'b1;
        w_state_nxt = (bus.req_valid & ~bus.req_wr) ? S_CHECK : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Storage array: corrected write-back or host write (never both at once)
  // ------------------------------------------------------------------------
  // Array update; reset clears every word to the valid all-zero codeword
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_corr) begin
      r_mem[r_chk_addr] <= {crc_f(w_fixed), w_fixed};
    end else if (w_acc_wr && w_req_inrange) begin
      r_mem[bus.req_addr] <= {crc_f(bus.req_wdata), bus.req_wdata} ^
                             (bus.err_inj_en ? bus.err_inj_mask : '0);
    end
  end

  // Capture the raw word for a read or scrub; out-of-range reads see zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_word  <= '0;
      r_chk_addr  <= '0;
      r_chk_scrub <= 1'b0;
    end else if (w_acc_rd) begin
      r_chk_word  <= w_req_inrange ? r_mem[bus.req_addr] : '0;
      r_chk_addr  <= bus.req_addr;
      r_chk_scrub <= 1'b0;
    end else if (w_scrub_issue) begin
      r_chk_word  <= r_mem[r_scrub_ptr];
      r_chk_addr  <= r_scrub_ptr;
      r_chk_scrub <= 1'b1;
    end
  end

  // Saturating error counters, updated at the end of every check cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_corr && (r_corr_cnt != 16'hFFFF))     r_corr_cnt   <= r_corr_cnt + 16'd1;
      if (w_uncorr && (r_uncorr_cnt != 16'hFFFF)) r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
    end
  end

  // Scrub pointer advances once per issued scrub and wraps at the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_scrub_ptr <= '0;
    else if (w_scrub_issue) r_scrub_ptr <= (r_scrub_ptr == c_PTR_LAST) ? '0 : r_scrub_ptr + 1'b1;
  end

  if (SCRUB_EN) begin : g_scrub
    logic [c_IW-1:0] r_iv_cnt;
    logic            r_pend;

    // Free-running interval timer; pending stays set until a scrub issues
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_iv_cnt <= '0;
        r_pend   <= 1'b0;
      end else begin
        r_iv_cnt <= (r_iv_cnt == c_IV_LAST) ? '0 : r_iv_cnt + 1'b1;
        if (r_iv_cnt == c_IV_LAST) r_pend <= 1'b1;
        else if (w_scrub_issue)    r_pend <= 1'b0;
      end
    end
    assign w_scrub_pending = r_pend;
  end else begin : g_no_scrub
    assign w_scrub_pending = 1'b0;
  end

  // ------------------------------------------------------------------------
  // Response stage
  // ------------------------------------------------------------------------
  if (OUTPUT_FF) begin : g_out_ff
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_det;
    logic                  r_rsp_corr;
    logic                  r_rsp_uncorr;

    // Register the host-read result; data and flags are zero between pulses
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rsp_valid  <= 1'b0;
        r_rsp_rdata  <= '0;
        r_rsp_det    <= 1'b0;
        r_rsp_corr   <= 1'b0;
        r_rsp_uncorr <= 1'b0;
      end else begin
        r_rsp_valid  <= w_rsp_fire;
        r_rsp_rdata  <= w_rsp_fire ? w_fixed : '0;
        r_rsp_det    <= w_rsp_fire & w_det;
        r_rsp_corr   <= w_rsp_fire & w_corr;
        r_rsp_uncorr <= w_rsp_fire & w_uncorr;
      end
    end
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.rsp_err_det    = r_rsp_det;
    assign bus.rsp_err_corr   = r_rsp_corr;
    assign bus.rsp_err_uncorr = r_rsp_uncorr;
  end else begin : g_out_comb
    assign bus.rsp_valid      = w_rsp_fire;
    assign bus.rsp_rdata      = w_rsp_fire ? w_fixed : '0;
    assign bus.rsp_err_det    = w_rsp_fire & w_det;
    assign bus.rsp_err_corr   = w_rsp_fire & w_corr;
    assign bus.rsp_err_uncorr = w_rsp_fire & w_uncorr;
  end

  assign bus.corr_cnt   = r_corr_cnt;
  assign bus.uncorr_cnt = r_uncorr_cnt;
  assign bus.scrub_ptr  = r_scrub_ptr;
endmodule
`default_nettype wire

// File: tb/tb_crc_scrub_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_crc_scrub_mem
// Description : Scoreboard bench for crc_scrub_mem. u_dut has the scrubber
//               off for deterministic error-path vectors; u_scr scrubs every
//               4 cycles. One request driver is steered to either instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_scrub_mem;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc_scrub_mem_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CRC_W(CW)) bus_a ();
  crc_scrub_mem_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CRC_W(CW)) bus_b ();

  crc_scrub_mem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CRC_W(CW), .POLY(8'h07),
                  .OUTPUT_FF(1'b1), .SCRUB_EN(1'b0), .SCRUB_INTERVAL(256))
    u_dut (.clk(clk), .rst(rst), .bus(bus_a));

  crc_scrub_mem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CRC_W(CW), .POLY(8'h07),
                  .OUTPUT_FF(1'b1), .SCRUB_EN(1'b1), .SCRUB_INTERVAL(4))
    u_scr (.clk(clk), .rst(rst), .bus(bus_b));

  // Shared request driver, steered by t_sel (0 = u_dut, 1 = u_scr)
  logic           t_sel   = 1'b0;
  logic           t_valid = 1'b0;
  logic           t_wr    = 1'b0;
  logic [3:0]     t_addr  = '0;
  logic [DW-1:0]  t_wdata = '0;
  logic           t_inj   = 1'b0;
  logic [DW+CW-1:0] t_mask = '0;

  assign bus_a.req_valid    = t_valid & ~t_sel;
  assign bus_b.req_valid    = t_valid & t_sel;
  assign bus_a.req_wr       = t_wr;
  assign bus_b.req_wr       = t_wr;
  assign bus_a.req_addr     = t_addr;
  assign bus_b.req_addr     = t_addr;
  assign bus_a.req_wdata    = t_wdata;
  assign bus_b.req_wdata    = t_wdata;
  assign bus_a.err_inj_en   = t_inj;
  assign bus_b.err_inj_en   = t_inj;
  assign bus_a.err_inj_mask = t_mask;
  assign bus_b.err_inj_mask = t_mask;

  wire w_ready = t_sel ? bus_b.req_ready : bus_a.req_ready;

  typedef struct {
    logic [DW-1:0] data;
    logic          det;
    logic          corr;
    logic          uncorr;
    int unsigned   cyc;
    string         tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  logic [3:0]  last_ptr_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever either instance presents a response
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.rsp_valid || bus_b.rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid with empty scoreboard, required none");
      end else begin
        e = sb_q.pop_front();
        if (bus_a.rsp_valid) begin
          check({e.tag, "_data"},   32'(bus_a.rsp_rdata),      32'(e.data));
          check({e.tag, "_det"},    32'(bus_a.rsp_err_det),    32'(e.det));
          check({e.tag, "_corr"},   32'(bus_a.rsp_err_corr),   32'(e.corr));
          check({e.tag, "_uncorr"}, 32'(bus_a.rsp_err_uncorr), 32'(e.uncorr));
        end else begin
          check({e.tag, "_data"},   32'(bus_b.rsp_rdata),      32'(e.data));
          check({e.tag, "_det"},    32'(bus_b.rsp_err_det),    32'(e.det));
          check({e.tag, "_corr"},   32'(bus_b.rsp_err_corr),   32'(e.corr));
          check({e.tag, "_uncorr"}, 32'(bus_b.rsp_err_uncorr), 32'(e.uncorr));
        end
        check({e.tag, "_latency"}, cyc - e.cyc, 32'd2);
      end
    end
  end

  // One request; reads push their expected response at handshake time
  task automatic do_req(input logic sel, input logic wr, input logic [3:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW+CW-1:0] mask,
                        input logic [DW-1:0] e_data, input logic e_det,
                        input logic e_corr, input logic e_uncorr, input string tag);
    int   waitc;
    exp_t e;
    @(negedge clk);
    t_sel   = sel;
    t_valid = 1'b1;
    t_wr    = wr;
    t_addr  = addr;
    t_wdata = wdata;
    t_inj   = (mask != '0);
    t_mask  = mask;
    waitc   = 0;
    while (!w_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!w_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_handshake: req_ready stayed 0, required 1 within 20 cycles", tag);
      t_valid = 1'b0;
      return;
    end
    last_ptr_b = bus_b.scrub_ptr;
    if (!wr) begin
      e.data = e_data; e.det = e_det; e.corr = e_corr; e.uncorr = e_uncorr;
      e.cyc  = cyc;    e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_inj   = 1'b0;
    t_mask  = '0;
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [DW-1:0] d,
                    input logic [DW+CW-1:0] mask);
    do_req(sel, 1'b1, addr, d, mask, '0, 1'b0, 1'b0, 1'b0, "wr");
  endtask

  task automatic rd(input logic sel, input logic [3:0] addr, input logic [DW-1:0] e_data,
                    input logic e_det, input logic e_corr, input logic e_uncorr,
                    input string tag);
    do_req(sel, 1'b0, addr, '0, '0, e_data, e_det, e_corr, e_uncorr, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] p0;
    logic [3:0] prev;
    logic       wrapped;
    logic       held;
    logic       changed;
    int         waitc;

    // Reset state
    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(bus_a.req_ready), 32'd0);
    check("rsp_valid_reset", 32'(bus_a.rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus_a.req_ready), 32'd1);
    check("corr_cnt_reset",    32'(bus_a.corr_cnt),   32'd0);
    check("uncorr_cnt_reset",  32'(bus_a.uncorr_cnt), 32'd0);
    check("scrub_ptr_reset",   32'(bus_a.scrub_ptr),  32'd0);

    // Reset contents read back as clean zero
    rd(1'b0, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b0, "rd_reset");

    // Plain write / read
    wr(1'b0, 4'd5, 16'h0001, '0);
    rd(1'b0, 4'd5, 16'h0001, 1'b0, 1'b0, 1'b0, "rd_clean5");
    idle(2);
    check("stored_word5", 32'(u_dut.r_mem[5]), 32'h0007_0001);

    // Single data-bit error: corrected, written back, one stall cycle
    wr(1'b0, 4'd5, 16'h0001, 24'h00_0001);
    rd(1'b0, 4'd5, 16'h0001, 1'b1, 1'b1, 1'b0, "rd_corr5");
    @(negedge clk);
    check("ready_stall_wb", 32'(bus_a.req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_wb", 32'(bus_a.req_ready), 32'd1);
    rd(1'b0, 4'd5, 16'h0001, 1'b0, 1'b0, 1'b0, "rd_after_corr5");
    idle(3);
    check("corr_cnt_1", 32'(bus_a.corr_cnt), 32'd1);
    check("wb_word5",   32'(u_dut.r_mem[5]), 32'h0007_0001);

    // Stored CRC bit error: data untouched, still counted as corrected
    wr(1'b0, 4'd6, 16'h1234, 24'h01_0000);
    rd(1'b0, 4'd6, 16'h1234, 1'b1, 1'b1, 1'b0, "rd_crcbit6");
    rd(1'b0, 4'd6, 16'h1234, 1'b0, 1'b0, 1'b0, "rd_after_crcbit6");
    idle(3);
    check("corr_cnt_2", 32'(bus_a.corr_cnt), 32'd2);

    // Double data-bit error: uncorrectable, raw data, no write-back
    wr(1'b0, 4'd8, 16'h00A5, 24'h00_0003);
    rd(1'b0, 4'd8, 16'h00A6, 1'b1, 1'b0, 1'b1, "rd_uncorr8");
    idle(3);
    check("uncorr_cnt_1", 32'(bus_a.uncorr_cnt), 32'd1);
    rd(1'b0, 4'd8, 16'h00A6, 1'b1, 1'b0, 1'b1, "rd_uncorr8_again");
    idle(3);
    check("uncorr_cnt_2", 32'(bus_a.uncorr_cnt), 32'd2);
    check("uncorr_no_wb", 32'(u_dut.r_mem[8]), 32'h0072_00A6);
    check("corr_cnt_still_2", 32'(bus_a.corr_cnt), 32'd2);

    // Read-after-write back to back, then a burst of back-to-back reads
    wr(1'b0, 4'd7, 16'hBEEF, '0);
    rd(1'b0, 4'd7, 16'hBEEF, 1'b0, 1'b0, 1'b0, "rd_raw7");
    rd(1'b0, 4'd5, 16'h0001, 1'b0, 1'b0, 1'b0, "b2b_5");
    rd(1'b0, 4'd6, 16'h1234, 1'b0, 1'b0, 1'b0, "b2b_6");
    rd(1'b0, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b0, "b2b_3");
    rd(1'b0, 4'd7, 16'hBEEF, 1'b0, 1'b0, 1'b0, "b2b_7");
    idle(4);

    // Scrubber: latent single-bit error in addr 2 is found and repaired
    wr(1'b1, 4'd2, 16'h5555, 24'h00_0010);
    wrapped = 1'b0;
    prev    = bus_b.scrub_ptr;
    for (int k = 0; k < DEPTH * 4 + 8; k++) begin
      @(negedge clk);
      if (prev == 4'd15 && bus_b.scrub_ptr == 4'd0) wrapped = 1'b1;
      prev = bus_b.scrub_ptr;
    end
    check("scrub_corr_cnt",   32'(bus_b.corr_cnt),   32'd1);
    check("scrub_uncorr_cnt", 32'(bus_b.uncorr_cnt), 32'd0);
    check("scrub_ptr_wrap",   32'(wrapped),          32'd1);
    check("scrub_wb_word2",   32'(u_scr.r_mem[2]),   32'h00E1_5555);
    rd(1'b1, 4'd2, 16'h5555, 1'b0, 1'b0, 1'b0, "rd_scrubbed2");

    // Continuous reads across scrub expiry: scrub waits for an idle cycle
    wr(1'b1, 4'd9,  16'h1357, '0);
    wr(1'b1, 4'd10, 16'h2468, '0);
    held = 1'b1;
    for (int k = 0; k < 12; k++) begin
      case (k % 3)
        0:       rd(1'b1, 4'd9,  16'h1357, 1'b0, 1'b0, 1'b0, "burst_9");
        1:       rd(1'b1, 4'd10, 16'h2468, 1'b0, 1'b0, 1'b0, "burst_10");
        default: rd(1'b1, 4'd2,  16'h5555, 1'b0, 1'b0, 1'b0, "burst_2");
      endcase
      if (k == 0) p0 = last_ptr_b;
      else if (last_ptr_b != p0) held = 1'b0;
    end
    check("scrub_deferred", 32'(held), 32'd1);
    changed = 1'b0;
    for (int k = 0; k < 10 && !changed; k++) begin
      @(negedge clk);
      if (bus_b.scrub_ptr != p0) changed = 1'b1;
    end
    check("scrub_after_burst", 32'(changed), 32'd1);
    check("scrub_ptr_next", 32'(bus_b.scrub_ptr), 32'(4'(p0 + 4'd1)));

    // Drain the scoreboard
    waitc = 0;
    while (sb_q.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
